// File: rtl/alu_exec_pkg.sv
// Shared types and sizes for the execute/write-back stage around the 8x16 register file.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_exec_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    // Shift amount width; a 4-bit amount can never reach DATA_W.
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SHL   = 3'b101,
        OP_MUL   = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_exec_seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// Latency: first step on the start edge, done high after DATA_W-1 further edges.
// Backpressure: none; a new start restarts the sequence unconditionally.
module seq_multiplier
    import alu_exec_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                w_last;

    // r_cnt counts multiplier bits already folded into r_acc.
    assign w_last  = (r_cnt == CNT_W'(DATA_W));
    assign done    = r_busy & w_last;
    assign product = r_acc;

    // Start folds bit 0 immediately so the last bit lands DATA_W-1 edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_acc    <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
            r_mcand  <= {{(DATA_W-1){1'b0}}, a, 1'b0};
            r_mplier <= b >> 1;
            r_cnt    <= CNT_W'(1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/write-back stage: reads two registers, runs ALU or multiply, writes result back.
// Latency: accept-to-write 2 cycles for ALU ops, DATA_W+1 cycles for MUL.
// Backpressure: issue_ready only in IDLE; one instruction in flight, offers elsewhere are ignored.
module alu_exec_stage
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_op,
    input  logic [ADDR_W-1:0] issue_srcA,
    input  logic [ADDR_W-1:0] issue_srcB,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic [ADDR_W-1:0] addre_rdA,
    output logic [ADDR_W-1:0] addre_rdB,
    input  logic [DATA_W-1:0] QA,
    input  logic [DATA_W-1:0] QB,
    output logic [DATA_W-1:0] D,
    output logic [ADDR_W-1:0] addre_wr,
    output logic              we,
    output logic              flag_zero,
    output logic              flag_carry
);

    state_e              r_state;
    state_e              w_next;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W-1:0]   r_srcA;
    logic [ADDR_W-1:0]   r_srcB;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_d;
    logic [ADDR_W-1:0]   r_wr;
    logic                r_zero;
    logic                r_carry;

    op_e                 w_issue_op;
    logic                w_accept;
    logic                w_mul_start;
    logic                w_mul_done;
    logic                w_capture;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_shl_full;
    logic [DATA_W-1:0]   w_res;
    logic                w_carry;

    assign w_issue_op  = op_e'(issue_op);
    assign w_accept    = issue_valid & (r_state == IDLE);
    assign w_mul_start = w_accept & (w_issue_op == OP_MUL);
    // Result registers load on the edge that enters WB.
    assign w_capture   = (r_state == EXEC) | ((r_state == MUL) & w_mul_done);

    seq_multiplier u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (QA),
        .b       (QB),
        .done    (w_mul_done),
        .product (w_product)
    );

    // State register; async reset aborts any in-flight instruction and drops we at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus handshake, read-address and write-enable outputs.
    always_comb begin
        w_next      = r_state;
        issue_ready = 1'b0;
        we          = 1'b0;
        addre_rdA   = r_srcA;
        addre_rdB   = r_srcB;
        case (r_state)
            IDLE: begin
                issue_ready = 1'b1;
                addre_rdA   = issue_srcA;
                addre_rdB   = issue_srcB;
                if (w_accept) begin
                    w_next = (w_issue_op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: w_next = WB;
            MUL:  if (w_mul_done) w_next = WB;
            WB: begin
                we     = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch: sources are captured at accept, so dst may alias a source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= OP_ADD;
            r_dst  <= '0;
            r_srcA <= '0;
            r_srcB <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else if (w_accept) begin
            r_op   <= w_issue_op;
            r_dst  <= issue_dst;
            r_srcA <= issue_srcA;
            r_srcB <= issue_srcB;
            r_a    <= QA;
            r_b    <= QB;
        end
    end

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    // Bit DATA_W of the widened shift is exactly the last bit pushed out (0 for a zero shift).
    assign w_shl_full = {{DATA_W{1'b0}}, r_a} << r_b[SHAMT_W-1:0];

    // Combinational result and carry for the latched operation.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_res   = r_a - r_b;
                w_carry = (r_a < r_b);
            end
            OP_AND:   w_res = r_a & r_b;
            OP_OR:    w_res = r_a | r_b;
            OP_XOR:   w_res = r_a ^ r_b;
            OP_SHL: begin
                w_res   = w_shl_full[DATA_W-1:0];
                w_carry = w_shl_full[DATA_W];
            end
            OP_MUL: begin
                w_res   = w_product[DATA_W-1:0];
                w_carry = |w_product[2*DATA_W-1:DATA_W];
            end
            OP_PASSA: w_res = r_a;
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    // Write-back registers; they hold their value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d     <= '0;
            r_wr    <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_capture) begin
            r_d     <= w_res;
            r_wr    <= r_dst;
            r_zero  <= (w_res == '0);
            r_carry <= w_carry;
        end
    end

    assign D          = r_d;
    assign addre_wr   = r_wr;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage with a behavioural 8x16 register file and reference model.
// Latency: measured per instruction from the accepting edge to the write-enable edge.
// Backpressure: offers are held until issue_ready, including a held-valid back-to-back run.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [2:0]  issue_srcA;
    logic [2:0]  issue_srcB;
    logic [2:0]  issue_dst;
    logic [2:0]  addre_rdA;
    logic [2:0]  addre_rdB;
    logic [15:0] QA;
    logic [15:0] QB;
    logic [15:0] D;
    logic [2:0]  addre_wr;
    logic        we;
    logic        flag_zero;
    logic        flag_carry;

    logic [15:0] rf [8];
    logic        bd_we = 1'b0;
    logic [2:0]  bd_addr = 3'd0;
    logic [15:0] bd_dat = 16'd0;
    int          wr_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned mdl [8];

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [2:0]  dst;
        logic [15:0] d;
        logic        c;
        logic        z;
        int          lat;
    } vec_t;

    vec_t tbl [9];
    vec_t shl_tbl [3];

    alu_exec_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_srcA  (issue_srcA),
        .issue_srcB  (issue_srcB),
        .issue_dst   (issue_dst),
        .addre_rdA   (addre_rdA),
        .addre_rdB   (addre_rdB),
        .QA          (QA),
        .QB          (QB),
        .D           (D),
        .addre_wr    (addre_wr),
        .we          (we),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry)
    );

    always #1 clk = ~clk;

    // Register file: combinational read, write at the clock edge.
    assign QA = rf[addre_rdA];
    assign QB = rf[addre_rdB];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we) begin
            rf[addre_wr] <= D;
            wr_cnt       <= wr_cnt + 1;
        end
        if (bd_we) rf[bd_addr] <= bd_dat;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_dat  = v;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Reference semantics written directly from the opcode definitions.
    function automatic void ref_exec(input int op, input int unsigned a, input int unsigned b,
                                     output int unsigned r, output bit c);
        longint unsigned full;
        int s;
        r = 0;
        c = 1'b0;
        case (op)
            0: begin full = longint'(a) + longint'(b); r = int'(full % 65536); c = (full >= 65536); end
            1: begin r = (a + 65536 - b) % 65536; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                s = int'(b % 16);
                full = longint'(a) << s;
                r = int'(full % 65536);
                c = (s != 0) && (((a >> (16 - s)) & 1) == 1);
            end
            6: begin full = longint'(a) * longint'(b); r = int'(full % 65536); c = (full >= 65536); end
            default: r = a;
        endcase
    endfunction

    // Offer one instruction, wait for accept and for the write-back pulse.
    task automatic do_issue(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                            input logic [2:0] dst, output int lat, output logic [15:0] d,
                            output logic c, output logic z, output logic [2:0] wa,
                            output logic ready_low);
        int n;
        lat = -1; d = 'x; c = 'x; z = 'x; wa = 'x; ready_low = 1'b1;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_srcA  = sa;
        issue_srcB  = sb;
        issue_dst   = dst;
        n = 0;
        while (issue_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (issue_ready !== 1'b1) begin
            issue_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
        lat = 1;
        while (we !== 1'b1 && lat < 40) begin
            if (issue_ready !== 1'b0) ready_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        d  = D;
        c  = flag_carry;
        z  = flag_zero;
        wa = addre_wr;
        @(posedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        logic [15:0] d;
        logic c, z, rl;
        logic [2:0] wa;
        do_issue(v.op, v.sa, v.sb, v.dst, lat, d, c, z, wa, rl);
        chk({tag, "_D"}, d, v.d);
        chk({tag, "_carry"}, c, v.c);
        chk({tag, "_zero"}, z, v.z);
        chk({tag, "_addr"}, wa, v.dst);
        chk({tag, "_lat"}, lat, v.lat);
        chk({tag, "_rdy_low"}, rl, 1'b1);
        @(negedge clk);
        chk({tag, "_rf"}, rf[v.dst], v.d);
    endtask

    initial begin
        int acc [3];
        int k, n, w0, lat;
        int unsigned er;
        bit ec;
        logic [2:0] op, sa, sb, dst, wa;
        logic [15:0] d;
        logic c, z, rl;

        // Directed vectors: seeding, ADD, SUB, read-back, MUL.
        tbl[0] = '{3'd7, 3'd0, 3'd0, 3'd1, 16'd10,    1'b0, 1'b0, 2};
        tbl[1] = '{3'd7, 3'd6, 3'd6, 3'd3, 16'd8,     1'b0, 1'b0, 2};
        tbl[2] = '{3'd0, 3'd1, 3'd3, 3'd5, 16'd18,    1'b0, 1'b0, 2};
        tbl[3] = '{3'd1, 3'd3, 3'd1, 3'd7, 16'hFFFE,  1'b1, 1'b0, 2};
        tbl[4] = '{3'd1, 3'd1, 3'd1, 3'd2, 16'h0000,  1'b0, 1'b1, 2};
        tbl[5] = '{3'd7, 3'd5, 3'd5, 3'd6, 16'd18,    1'b0, 1'b0, 2};
        tbl[6] = '{3'd7, 3'd4, 3'd4, 3'd1, 16'd300,   1'b0, 1'b0, 2};
        tbl[7] = '{3'd7, 3'd4, 3'd4, 3'd3, 16'd300,   1'b0, 1'b0, 2};
        tbl[8] = '{3'd6, 3'd1, 3'd3, 3'd4, 16'h5F90,  1'b1, 1'b0, 17};
        // SHL by 1, by 0 and by 15 of 0x8001 (R0=1, R2=0, R7=15).
        shl_tbl[0] = '{3'd5, 3'd1, 3'd0, 3'd5, 16'h0002, 1'b1, 1'b0, 2};
        shl_tbl[1] = '{3'd5, 3'd1, 3'd2, 3'd6, 16'h8001, 1'b0, 1'b0, 2};
        shl_tbl[2] = '{3'd5, 3'd1, 3'd7, 3'd3, 16'h8000, 1'b0, 1'b0, 2};

        rst_n = 1'b0;
        issue_valid = 1'b0;
        issue_op = 3'd0;
        issue_srcA = 3'd0;
        issue_srcB = 3'd0;
        issue_dst = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", issue_ready, 1'b1);
        chk("rst_we", we, 1'b0);
        chk("rst_D", D, 16'h0);
        chk("rst_addr", addre_wr, 3'd0);
        chk("rst_zero", flag_zero, 1'b0);
        chk("rst_carry", flag_carry, 1'b0);
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) poke(3'(r), 16'd0);
        poke(3'd0, 16'd10);
        poke(3'd6, 16'd8);
        poke(3'd4, 16'd300);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("row%0d", i));

        // Held valid: three ADD R4+R4->R4, each reading the previous write.
        poke(3'd4, 16'h1357);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = 3'd0;
        issue_srcA = 3'd4;
        issue_srcB = 3'd4;
        issue_dst = 3'd4;
        k = 0;
        n = 0;
        while (k < 3 && n < 40) begin
            if (issue_ready === 1'b1) begin
                acc[k] = cyc;
                k++;
            end
            @(negedge clk);
            n++;
        end
        issue_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_accepts", k, 3);
        chk("b2b_gap1", acc[1] - acc[0], 3);
        chk("b2b_gap2", acc[2] - acc[1], 3);
        chk("b2b_R4", rf[4], 16'h9AB8);

        // Reset in the middle of a multiply must suppress the write.
        poke(3'd1, 16'd300);
        poke(3'd3, 16'd7);
        poke(3'd4, 16'h1234);
        w0 = wr_cnt;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = 3'd6;
        issue_srcA = 3'd1;
        issue_srcB = 3'd3;
        issue_dst = 3'd4;
        n = 0;
        while (issue_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
        chk("rstmul_busy", issue_ready, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmul_we", we, 1'b0);
        chk("rstmul_ready_in_rst", issue_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmul_ready", issue_ready, 1'b1);
        chk("rstmul_D", D, 16'h0);
        repeat (20) @(negedge clk);
        chk("rstmul_writes", wr_cnt - w0, 0);
        chk("rstmul_R4", rf[4], 16'h1234);

        poke(3'd1, 16'h8001);
        poke(3'd0, 16'd1);
        poke(3'd2, 16'd0);
        poke(3'd7, 16'd15);
        for (int i = 0; i < 3; i++) run_vec(shl_tbl[i], $sformatf("shl%0d", i));

        // Random instructions against the reference model.
        for (int r = 0; r < 8; r++) begin
            mdl[r] = $urandom_range(0, 65535);
            if (r == 2) mdl[r] = 0;
            if (r == 5) mdl[r] = 16'hFFFF;
            poke(3'(r), 16'(mdl[r]));
        end
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            sa  = 3'($urandom_range(0, 7));
            sb  = 3'($urandom_range(0, 7));
            dst = 3'($urandom_range(0, 7));
            ref_exec(int'(op), mdl[sa], mdl[sb], er, ec);
            do_issue(op, sa, sb, dst, lat, d, c, z, wa, rl);
            chk($sformatf("rnd%0d_op%0d_D", i, op), d, er);
            chk($sformatf("rnd%0d_op%0d_carry", i, op), c, ec);
            chk($sformatf("rnd%0d_op%0d_zero", i, op), z, (er == 0));
            chk($sformatf("rnd%0d_addr", i), wa, dst);
            chk($sformatf("rnd%0d_lat", i), lat, (op == 3'd6) ? 17 : 2);
            mdl[dst] = er;
        end
        @(negedge clk);
        for (int r = 0; r < 8; r++) chk($sformatf("rnd_final_R%0d", r), rf[r], mdl[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
